// File: rtl/g_norn_filt_if.sv
// Signal bundle for g_norn_filt: filter enable, OR inputs and filtered/raw/edge outputs.
// The CLR/STICKY pair exists only when G_NORN_STICKY_EN is defined.
interface g_norn_filt_if #(
   parameter int WIDTH = 4
);
   logic             CE;
   logic [WIDTH-1:0] A;
   logic             Y;
   logic             YRAW;
   logic             RISE;
   logic             FALL;
`ifdef G_NORN_STICKY_EN
   logic             CLR;
   logic             STICKY;
`endif

   modport master (
      output CE, A,
`ifdef G_NORN_STICKY_EN
      output CLR,
      input  STICKY,
`endif
      input  Y, YRAW, RISE, FALL
   );

   modport slave (
      input  CE, A,
`ifdef G_NORN_STICKY_EN
      input  CLR,
      output STICKY,
`endif
      output Y, YRAW, RISE, FALL
   );
endinterface

// File: rtl/g_norn_filt.sv
// N-input mixed-polarity OR with input synchroniser, CE-gated consecutive-cycle filter and edge pulses.
// Optional sticky rise flag with synchronous clear is enabled by defining G_NORN_STICKY_EN.
//
// state   | meaning
// STABLE  | term agrees with Y, no run in progress
// PENDING | term disagrees with Y, cnt counts qualifying CE cycles seen so far
module g_norn_filt #(
   parameter int               WIDTH       = 4,
   parameter logic [WIDTH-1:0] INV_MASK    = WIDTH'(4'b0011),
   parameter int               SYNC_STAGES = 2,
   parameter int               FILT_CYCLES = 4,
   parameter logic             RESET_VAL   = 1'b0
) (
   input logic          CK,
   input logic          RN,
   g_norn_filt_if.slave bus
);

   localparam int CW = $clog2(FILT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("g_norn_filt: WIDTH out of range 2..32");
   end
   if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
      $error("g_norn_filt: SYNC_STAGES out of range 0..3");
   end
   if (FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_bad_filt
      $error("g_norn_filt: FILT_CYCLES out of range 1..255");
   end
   if ($bits(bus.A) != WIDTH) begin : g_bad_bus
      $error("g_norn_filt: interface WIDTH does not match module WIDTH");
   end

   typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} state_t;

   logic [WIDTH-1:0] a_sync;
   logic             term;
   logic             yraw_q;
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             y_q, y_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   // Sync flops reset to INV_MASK so the term reads inactive out of reset.
   if (SYNC_STAGES == 0) begin : g_nosync
      assign a_sync = bus.A;
   end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge CK or negedge RN) begin
         if (!RN) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= INV_MASK;
         end else begin
            sync_q[0] <= bus.A;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         end
      end
      assign a_sync = sync_q[SYNC_STAGES-1];
   end

   assign term = |(a_sync ^ INV_MASK);

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         yraw_q  <= 1'b0;
         state_q <= STABLE;
         cnt_q   <= '0;
         y_q     <= RESET_VAL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         yraw_q  <= term;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      if (bus.CE) begin
         case (state_q)
            STABLE: begin
               if (term != y_q) begin
                  if (FILT_CYCLES == 1) begin
                     y_d = term;
                  end else begin
                     cnt_d   = CW'(1);
                     state_d = PENDING;
                  end
               end
            end
            PENDING: begin
               if (term == y_q) begin
                  cnt_d   = '0;
                  state_d = STABLE;
               end else if (cnt_q == CNT_LAST) begin
                  y_d     = term;
                  cnt_d   = '0;
                  state_d = STABLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = STABLE;
            end
         endcase
      end
   end

   // y_d only differs from y_q on a committing CE edge, so pulses self-clear next edge.
   always_comb begin
      rise_d = y_d & ~y_q;
      fall_d = ~y_d & y_q;
   end

   assign bus.Y    = y_q;
   assign bus.YRAW = yraw_q;
   assign bus.RISE = rise_q;
   assign bus.FALL = fall_q;

`ifdef G_NORN_STICKY_EN
   logic sticky_q;

   always_ff @(posedge CK or negedge RN) begin
      if (!RN)          sticky_q <= 1'b0;
      else if (rise_d)  sticky_q <= 1'b1;
      else if (bus.CLR) sticky_q <= 1'b0;
   end

   assign bus.STICKY = sticky_q;
`endif

endmodule
